// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with a configurable [MIN_VAL, MAX_VAL] range,
// wrap or saturate behaviour at the limits, synchronous load and enable,
// a lookahead terminal-count flag and sticky overflow/underflow flags.
module param_up_down_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MAX_VAL  = 15,
   parameter int unsigned MIN_VAL  = 0,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             upordown,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             flag_clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] MinV = WIDTH'(MIN_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             at_max, at_min;
   logic             up_evt, dn_evt;
   logic [WIDTH-1:0] load_clamped;

   // Limit detection and limit events; compared before any arithmetic so that
   // MAX_VAL = 2**WIDTH-1 never needs a carry out.
   always_comb begin
      at_max = (count_q == MaxV);
      at_min = (count_q == MinV);
      up_evt = en & ~load & ~upordown & at_max;
      dn_evt = en & ~load &  upordown & at_min;
   end

   // Clamp the parallel-load value into the legal count range.
   always_comb begin
      load_clamped = load_val;
      if (load_val <= MinV) begin
         load_clamped = MinV;
      end else if (load_val >= MaxV) begin
         load_clamped = MaxV;
      end
   end

   // Next-state: load has priority, then enabled up/down counting.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = load_clamped;
      end else if (en) begin
         if (!upordown) begin
            if (at_max) begin
               count_d = SATURATE ? MaxV : MinV;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (at_min) begin
               count_d = SATURATE ? MinV : MaxV;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   // Sticky flags: a limit event in the same cycle as flag_clr wins.
   always_comb begin
      ovf_d = up_evt | (ovf_q & ~flag_clr);
      unf_d = dn_evt | (unf_q & ~flag_clr);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= MinV;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Outputs; tc is the lookahead of the wrap pulse.
   always_comb begin
      count = count_q;
      wrap  = wrap_q;
      ovf   = ovf_q;
      unf   = unf_q;
      tc    = up_evt | dn_evt;
   end

endmodule

// File: doc/param_up_down_counter.md
Name: param_up_down_counter

Overview:
Parametrised successor to the team's fixed 4-bit up/down counter. Adds configurable width and count range, selectable wrap or saturate mode, synchronous enable and parallel load, a lookahead terminal-count flag, and sticky overflow/underflow flags. It is a drop-in timing/sequencing counter for later blocks: timers, address generators and loop counters.

Parameters:
WIDTH, 4, counter width in bits.
MAX_VAL, 15, upper count limit; MIN_VAL < MAX_VAL <= 2**WIDTH-1.
MIN_VAL, 0, lower count limit.
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
clk  input  1  rising-edge clock, the only clock.
reset  input  1  asynchronous, active-high reset.
en  input  1  count enable, sampled on clk.
upordown  input  1  direction: 0 = up, 1 = down.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value to load.
flag_clr  input  1  synchronous clear of the sticky flags.
count  output  WIDTH  registered count value.
tc  output  1  combinational terminal count (see below).
wrap  output  1  registered one-cycle pulse on a limit event.
ovf  output  1  sticky flag: up-count attempted at MAX_VAL.
unf  output  1  sticky flag: down-count attempted at MIN_VAL.

Behaviour:
- Reset (async, immediate, independent of clk): count=MIN_VAL, wrap=0, ovf=0, unf=0. tc then follows its equation.
- Each rising clk edge, with reset low, applies the first matching rule:
  1. load=1: count <= load_val clamped to [MIN_VAL, MAX_VAL]. No wrap pulse. Flags are not set by a load. en and upordown are ignored.
  2. en=1, upordown=0: if count<MAX_VAL, count <= count+1. If count==MAX_VAL, count becomes MIN_VAL (SATURATE=0) or holds at MAX_VAL (SATURATE=1). Either way wrap=1 for one cycle and ovf<=1.
  3. en=1, upordown=1: if count>MIN_VAL, count <= count-1. If count==MIN_VAL, count becomes MAX_VAL (SATURATE=0) or holds at MIN_VAL (SATURATE=1). Either way wrap=1 for one cycle and unf<=1.
  4. en=0: count holds, wrap=0.
- wrap is 0 on every cycle without a limit event.
- tc = en & ~load & ((~upordown & count==MAX_VAL) | (upordown & count==MIN_VAL)). It is combinational and asserts in the cycle before the edge at which wrap rises.
- flag_clr=1 clears ovf and unf on the edge. If a limit event occurs in the same cycle, the set wins: the flag reads 1 after the edge.
- Changing direction mid-count takes effect on the next edge. There is no dead cycle.
- count never leaves [MIN_VAL, MAX_VAL] after reset, in any mode.
- Arithmetic is WIDTH bits, unsigned. Limit comparisons are evaluated before the increment or decrement, so no intermediate overflow occurs even when MAX_VAL = 2**WIDTH-1.
- Reset asserted mid-count forces the reset values asynchronously. Counting resumes on the first edge after reset deasserts.
- Latency: 1 clk from input to count/wrap/flags. tc has zero latency.

Test Plan:
- Defaults, upordown=0, en=1 after reset for 18 clocks -> count 0,1..15,0,1. wrap high exactly on the cycle count shows 0 after 15. tc high while count=15. ovf=1 from that edge onward.
- Defaults, upordown=1 from reset -> count 15,14,… after the first edge. wrap pulses on the 0->15 step. unf=1, ovf stays 0.
- SATURATE=1, MIN_VAL=2, MAX_VAL=9, count up 10 clocks -> count 2..9 then held at 9. wrap pulses once per clock while held. Down-count from 9 holds at 2.
- MIN_VAL=2, MAX_VAL=9: load with load_val=12 -> count=9. load_val=0 -> count=2. load=1 with en=1 -> load wins. No wrap pulse and flags unchanged.
- Set ovf, then flag_clr=1 alone -> ovf=0 next edge. flag_clr=1 on the same cycle as an up-event at MAX_VAL -> ovf=1 after the edge.
- Assert reset between clock edges at count=7 -> count=0 and flags=0 immediately. en=0 for 3 clocks after release -> count holds at 0.
